// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial CLA subtractor.
//   NIB_W        : width of one carry-lookahead slice.
//   cla_state_e  : FSM state encoding (IDLE / RUN / DONE).
//   cla_nibs()   : number of nibbles in a WIDTH-bit operand.
//   cla_idx_w()  : width of the nibble index register.
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } cla_state_e;

    function automatic int cla_nibs(input int width);
        return width / NIB_W;
    endfunction

    function automatic int cla_idx_w(input int width);
        return $clog2(width / NIB_W);
    endfunction

endpackage

// File: rtl/cla_subtractor_seq_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
//   i_a, i_b : nibble operands
//   i_c      : carry in
//   o_sum    : 4-bit sum
//   o_c      : carry out
module cla4_slice
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_c,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_c
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Every carry is expanded directly from generate/propagate terms so no
    // carry ripples through another within the slice.
    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_sum = w_p ^ w_c[3:0];
    assign o_c   = w_c[4];

endmodule

// File: rtl/cla_subtractor_seq.sv
// Nibble-serial two's-complement subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin one 4-bit CLA slice per clock.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, bin)
//   out_valid / out_ready: result handshake (diff, bout, zero, ovf)
//   dbg_state            : current FSM state for observation
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1; valid, once raised, holds with its data until that edge.
module cla_subtractor_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int NIBS  = cla_nibs(WIDTH);
    localparam int IDX_W = cla_idx_w(WIDTH);

    cla_state_e       r_state;
    logic [WIDTH-1:0] r_a;       // shifts right one nibble per RUN cycle
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;     // partial difference, filled from the top
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_zacc;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;
    logic             r_ovf;
    logic             r_out_valid;

    logic [NIB_W-1:0] w_nb;
    logic [NIB_W-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_nb       = ~r_b[NIB_W-1:0];
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:NIB_W]};
    assign w_last     = (r_idx == IDX_W'(NIBS - 1));

    cla4_slice u_slice (
        .i_a   (r_a[NIB_W-1:0]),
        .i_b   (w_nb),
        .i_c   (r_carry),
        .o_sum (w_sum),
        .o_c   (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_zacc      <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_carry <= ~bin;
                        r_idx   <= '0;
                        r_zacc  <= 1'b1;
                        r_acc   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> NIB_W;
                    r_b     <= r_b >> NIB_W;
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    r_zacc  <= r_zacc & (w_sum == '0);
                    if (w_last) begin
                        // Result registers load only here, so a partial
                        // difference never reaches the outputs.
                        r_diff      <= w_acc_next;
                        r_bout      <= ~w_cout;
                        r_zero      <= r_zacc & (w_sum == '0);
                        r_ovf       <= (r_a_msb ^ r_b_msb) & (w_sum[NIB_W-1] ^ r_a_msb);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = rst_n & (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: doc/cla_subtractor_seq.md
# cla_subtractor_seq

Multi-cycle, nibble-serial two's-complement subtractor for the arithmetic datapath. It computes A − B − Bin over WIDTH bits, one 4-bit carry-lookahead slice per clock, using A + ~B + ~Bin. Operands and results move through valid/ready handshakes. It complements the team's combinational 4-bit CLA adder, and its borrow-out and flag outputs feed compare and branch logic.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of 4 and at least 8.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in (1 = subtract an extra 1).
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  A − B − Bin, modulo 2^WIDTH.
- bout  output  1  unsigned borrow out; 1 when A < B + Bin.
- zero  output  1  diff == 0.
- ovf  output  1  signed overflow.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&in_ready, register a, b and bin.
  - Set carry=~bin and nibble index=0, then go to RUN.
  - Later changes on a, b or bin have no effect on the operation in flight.
- **RUN:** each cycle processes nibble i with a 4-bit CLA: {c_out, d[4i+3:4i]} = a_n + ~b_n + carry.
  - carry ← c_out, i ← i+1.
  - After nibble WIDTH/4−1, go to DONE.
- **DONE:** out_valid=1.
  - diff, bout, zero and ovf stay stable until out_valid&out_ready, then go to IDLE.
- **Flags:**
  - bout = ~final carry.
  - zero = (diff==0).
  - ovf = (a[MSB]≠b[MSB]) & (diff[MSB]≠a[MSB]).
  - bin does not enter the ovf equation; a borrow-in at the signed boundary is covered by the diff sign test.
- **Backpressure:** DONE is held indefinitely while out_ready=0. in_ready stays 0 meanwhile.
- **No overlap:** in_ready is asserted only in IDLE. A handshake out in DONE and an operand offer in the same cycle are not merged; the new operand is accepted on the following IDLE cycle.
- **Reset mid-operation:** rst_n=0 at any edge aborts the operation, discards the result and returns to IDLE. No partial result is ever presented.

## Timing
- **Reset values** (after an edge with rst_n=0): state IDLE; out_valid=0, diff=0, bout=0, zero=0, ovf=0.
- **in_ready:** forced 0 while rst_n=0; 1 in the first cycle after reset deassertion.
- **Latency:** out_valid rises WIDTH/4 edges after the accept edge (8 for WIDTH=32).
- **Throughput:** one operation per WIDTH/4+2 cycles with out_ready held high.
- **Registered outputs:** all outputs except in_ready come from flops. in_ready is decoded from state and rst_n only.
- **Zero-flag path:** zero is accumulated per nibble (zero_acc &= (d_n==0)) so there is no WIDTH-wide reduction in the final cycle.

## Structure
- **Package cla_pkg:** NIB_W=4, the state enum (IDLE/RUN/DONE), and a localparam helper for nibble count and index width ($clog2(WIDTH/4)).
- **Sub-module cla4_slice:** combinational 4-bit generate/propagate carry-lookahead adder with carry in/out. It is instantiated once and fed the current nibble of a and ~b via index muxes or shift registers.
- **Top level:** FSM, operand and result registers, flag logic.

## Test plan
All scenarios use WIDTH=32.
- **Basic:** a=5, b=3, bin=0 → diff=0x00000002, bout=0, zero=0, ovf=0. out_valid rises exactly 8 edges after accept.
- **Wrap:** a=0, b=1 → diff=0xFFFFFFFF, bout=1, ovf=0.
- **Signed overflow and borrow-in:**
  - a=0x80000000, b=1 → diff=0x7FFFFFFF, ovf=1, bout=0.
  - a=10, b=3, bin=1 → diff=6.
- **Equality:** a=b=0xDEADBEEF → diff=0, zero=1, bout=0.
  - a=0, b=0, bin=1 → diff=0xFFFFFFFF, zero=0, bout=1.
- **Backpressure and back-to-back:** hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Release with in_valid high and new operands → new operands accepted on the cycle after the output handshake, and the second result is correct.
- **Reset mid-RUN:** assert rst_n=0 at nibble 4 → next cycle in IDLE, out_valid=0 and outputs 0. in_ready=1 once rst_n=1, and the next operation's result is correct.
